// File: rtl/pulse_arbiter_pkg.sv
// Shared helpers for the pulse arbiter slice: width derivation for index and counter fields.
package pulse_arbiter_pkg;

   // Bits needed to encode 0..n-1, never less than one bit.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first set pending bit searching upward (mod NUM_REQ) from ptr+1.
module rr_priority_select
   import pulse_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDW     = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] pending,
   input  logic [IDW-1:0]     ptr,
   output logic               any,
   output logic [IDW-1:0]     winner
);

   int unsigned idx;

   // Scan from the farthest offset down so the nearest candidate is written last and wins.
   always_comb begin
      any    = 1'b0;
      winner = '0;
      idx    = 0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (pending[idx]) begin
            any    = 1'b1;
            winner = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/pulse_arbiter.sv
// Round-robin arbiter funnelling single-cycle event pulses onto one valid/ready port,
// with a forced idle gap after every accepted event.
module pulse_arbiter
   import pulse_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int MIN_GAP = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req_pulse,
   output logic                          out_valid,
   output logic [idx_width(NUM_REQ)-1:0] out_id,
   input  logic                          out_ready,
   output logic [NUM_REQ-1:0]            pending,
   output logic [NUM_REQ-1:0]            overflow,
   input  logic [NUM_REQ-1:0]            clear_overflow
);

   localparam int IDW = idx_width(NUM_REQ);
   localparam int GW  = idx_width(MIN_GAP + 1);
   // The grant decision is registered, so the cycle that arbitrates is already the last idle one;
   // loading MIN_GAP-1 yields exactly MIN_GAP idle cycles on out_valid.
   localparam int GAP_LOAD = (MIN_GAP > 0) ? MIN_GAP - 1 : 0;

   logic [NUM_REQ-1:0] pending_q, pending_d;
   logic [NUM_REQ-1:0] overflow_q, overflow_d;
   logic               out_valid_q, out_valid_d;
   logic [IDW-1:0]     out_id_q, out_id_d;
   logic [IDW-1:0]     ptr_q, ptr_d;
   logic [GW-1:0]      gap_q, gap_d;

   logic               sel_any;
   logic [IDW-1:0]     sel_winner;
   logic               handshake;
   logic               grant;
   logic [NUM_REQ-1:0] served;

   rr_priority_select #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_sel (
      .pending (pending_q),
      .ptr     (ptr_q),
      .any     (sel_any),
      .winner  (sel_winner)
   );

   always_comb begin
      handshake = out_valid_q & out_ready;
      grant     = ~out_valid_q & (gap_q == '0) & sel_any;

      served = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         served[i] = handshake && (out_id_q == IDW'(i));
      end

      // A pulse landing on the event being accepted re-queues rather than overflowing.
      pending_d  = (pending_q & ~served) | req_pulse;
      overflow_d = (req_pulse & pending_q & ~served) | (overflow_q & ~clear_overflow);

      out_valid_d = out_valid_q;
      out_id_d    = out_id_q;
      ptr_d       = ptr_q;
      if (handshake) begin
         out_valid_d = 1'b0;
      end else if (grant) begin
         out_valid_d = 1'b1;
         out_id_d    = sel_winner;
         ptr_d       = sel_winner;
      end

      gap_d = gap_q;
      if (handshake) begin
         gap_d = GW'(GAP_LOAD);
      end else if (gap_q != '0) begin
         gap_d = gap_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pending_q   <= '0;
         overflow_q  <= '0;
         out_valid_q <= 1'b0;
         out_id_q    <= '0;
         ptr_q       <= IDW'(NUM_REQ - 1);
         gap_q       <= '0;
      end else begin
         pending_q   <= pending_d;
         overflow_q  <= overflow_d;
         out_valid_q <= out_valid_d;
         out_id_q    <= out_id_d;
         ptr_q       <= ptr_d;
         gap_q       <= gap_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_id    = out_id_q;
   assign pending   = pending_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_pulse_arbiter.sv
// Bench for pulse_arbiter: fixed vector table, hand-written corner sequences, then random traffic vs a model.
module tb_pulse_arbiter;

   localparam int N = 4;
   localparam int G = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] req_pulse = '0;
   logic       out_valid;
   logic [1:0] out_id;
   logic       out_ready = 1'b1;
   logic [3:0] pending;
   logic [3:0] overflow;
   logic [3:0] clear_overflow = '0;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   pulse_arbiter #(.NUM_REQ(N), .MIN_GAP(G)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .req_pulse      (req_pulse),
      .out_valid      (out_valid),
      .out_id         (out_id),
      .out_ready      (out_ready),
      .pending        (pending),
      .overflow       (overflow),
      .clear_overflow (clear_overflow)
   );

   // Reference model: events as a per-source flag set, the idle gap as an absolute
   // "earliest arbitration cycle" timestamp, round-robin as "last winner + offset".
   bit [3:0] m_pend, m_ovf;
   bit       m_valid;
   int       m_id, m_last, m_ok, m_cyc;

   task automatic model_step();
      bit       hs;
      bit       can_grant;
      int       w;
      bit [3:0] np, no;
      if (!reset_n) begin
         m_pend = '0; m_ovf = '0; m_valid = 0; m_id = 0; m_last = N - 1; m_ok = 0;
      end else begin
         hs = m_valid && out_ready;
         can_grant = !m_valid && (m_cyc >= m_ok) && (m_pend != 0);
         w = -1;
         for (int k = 1; k <= N; k++)
            if (w < 0 && m_pend[(m_last + k) % N]) w = (m_last + k) % N;
         for (int i = 0; i < N; i++) begin
            bit taken;
            taken = hs && (m_id == i);
            np[i] = (m_pend[i] && !taken) || req_pulse[i];
            no[i] = (req_pulse[i] && m_pend[i] && !taken) || (m_ovf[i] && !clear_overflow[i]);
         end
         m_pend = np;
         m_ovf  = no;
         if (hs) begin
            m_valid = 0;
            m_ok    = m_cyc + G;   // arbitration allowed G cycles later, out_valid one after that
         end else if (can_grant) begin
            m_valid = 1; m_id = w; m_last = w;
         end
      end
      m_cyc++;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic do_reset();
      req_pulse = '0; clear_overflow = '0; out_ready = 1'b1;
      reset_n = 1'b0;
      cyc();
      reset_n = 1'b1;
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_id", int'(out_id), 0);
      chk("rst_pending", int'(pending), 0);
      chk("rst_overflow", int'(overflow), 0);
   endtask

   task automatic wait_valid(input int maxc, output bit ok);
      ok = 0;
      for (int c = 0; c < maxc && !ok; c++) begin
         cyc();
         req_pulse = '0;
         if (out_valid) ok = 1;
      end
   endtask

   typedef struct {
      logic [3:0] req;
      logic       rdy;
      logic [3:0] clr;
      logic       vld;
      logic [1:0] id;
      logic [3:0] pend;
      logic [3:0] ovf;
   } vec_t;

   function automatic vec_t mk(logic [3:0] r, logic y, logic [3:0] c,
                               logic v, logic [1:0] i, logic [3:0] p, logic [3:0] o);
      vec_t t;
      t.req = r; t.rdy = y; t.clr = c; t.vld = v; t.id = i; t.pend = p; t.ovf = o;
      return t;
   endfunction

   vec_t tbl[26];

   initial begin
      bit ok;
      int rises, last_rise, exp_id;
      bit prev_v, latched, served;
      int grants_since;

      // Each row: inputs held for one cycle, expected registered outputs after that edge.
      tbl[0]  = mk(4'b0100, 1, 4'b0000, 0, 0, 4'b0100, 4'b0000);
      tbl[1]  = mk(4'b0000, 1, 4'b0000, 1, 2, 4'b0100, 4'b0000);
      tbl[2]  = mk(4'b0000, 1, 4'b0000, 0, 2, 4'b0000, 4'b0000);
      tbl[3]  = mk(4'b0010, 0, 4'b0000, 0, 2, 4'b0010, 4'b0000);
      tbl[4]  = mk(4'b0000, 0, 4'b0000, 0, 2, 4'b0010, 4'b0000);
      tbl[5]  = mk(4'b0000, 0, 4'b0000, 0, 2, 4'b0010, 4'b0000);
      tbl[6]  = mk(4'b0000, 0, 4'b0000, 1, 1, 4'b0010, 4'b0000);
      tbl[7]  = mk(4'b0010, 0, 4'b0000, 1, 1, 4'b0010, 4'b0010);
      tbl[8]  = mk(4'b0000, 0, 4'b0000, 1, 1, 4'b0010, 4'b0010);
      tbl[9]  = mk(4'b0000, 0, 4'b0010, 1, 1, 4'b0010, 4'b0000);
      tbl[10] = mk(4'b0000, 1, 4'b0000, 0, 1, 4'b0000, 4'b0000);
      tbl[11] = mk(4'b1000, 1, 4'b0000, 0, 1, 4'b1000, 4'b0000);
      tbl[12] = mk(4'b0000, 1, 4'b0000, 0, 1, 4'b1000, 4'b0000);
      tbl[13] = mk(4'b0000, 1, 4'b0000, 0, 1, 4'b1000, 4'b0000);
      tbl[14] = mk(4'b0000, 1, 4'b0000, 1, 3, 4'b1000, 4'b0000);
      tbl[15] = mk(4'b1000, 1, 4'b0000, 0, 3, 4'b1000, 4'b0000);
      tbl[16] = mk(4'b0000, 1, 4'b0000, 0, 3, 4'b1000, 4'b0000);
      tbl[17] = mk(4'b0000, 1, 4'b0000, 0, 3, 4'b1000, 4'b0000);
      tbl[18] = mk(4'b0000, 1, 4'b0000, 0, 3, 4'b1000, 4'b0000);
      tbl[19] = mk(4'b0000, 1, 4'b0000, 1, 3, 4'b1000, 4'b0000);
      tbl[20] = mk(4'b0000, 1, 4'b0000, 0, 3, 4'b0000, 4'b0000);
      tbl[21] = mk(4'b0100, 0, 4'b0000, 0, 3, 4'b0100, 4'b0000);
      tbl[22] = mk(4'b0100, 0, 4'b0000, 0, 3, 4'b0100, 4'b0100);
      tbl[23] = mk(4'b0100, 0, 4'b0100, 0, 3, 4'b0100, 4'b0100);
      tbl[24] = mk(4'b0000, 0, 4'b0100, 1, 2, 4'b0100, 4'b0000);
      tbl[25] = mk(4'b0000, 1, 4'b0000, 0, 2, 4'b0000, 4'b0000);

      m_cyc = 0;
      cyc();
      do_reset();

      for (int k = 0; k < 26; k++) begin
         req_pulse = tbl[k].req; out_ready = tbl[k].rdy; clear_overflow = tbl[k].clr;
         cyc();
         chk($sformatf("tbl[%0d].valid", k), int'(out_valid), int'(tbl[k].vld));
         chk($sformatf("tbl[%0d].id", k), int'(out_id), int'(tbl[k].id));
         chk($sformatf("tbl[%0d].pending", k), int'(pending), int'(tbl[k].pend));
         chk($sformatf("tbl[%0d].overflow", k), int'(overflow), int'(tbl[k].ovf));
      end

      // All four requesters at once: grants 0..3, valid rising every G+1 cycles.
      do_reset();
      req_pulse = 4'b1111;
      rises = 0; last_rise = 0; prev_v = 0;
      for (int c = 0; c < 40; c++) begin
         cyc();
         req_pulse = '0;
         if (out_valid && !prev_v) begin
            if (rises < 4) chk($sformatf("burst_id%0d", rises), int'(out_id), rises);
            if (rises > 0) chk($sformatf("burst_gap%0d", rises), c - last_rise, G + 1);
            else chk("burst_first_latency", c, 1);
            last_rise = c;
            rises++;
         end
         prev_v = out_valid;
      end
      chk("burst_grant_count", rises, 4);

      // Long stall on id 1: held stable, repeated pulse overflows, clear drops it.
      do_reset();
      req_pulse = 4'b0010; out_ready = 1'b0;
      wait_valid(10, ok);
      chk("hold_granted", int'(ok), 1);
      for (int c = 0; c < 10; c++) begin
         req_pulse = (c == 3) ? 4'b0010 : 4'b0000;
         cyc();
         chk("hold_valid", int'(out_valid), 1);
         chk("hold_id", int'(out_id), 1);
      end
      req_pulse = '0;
      chk("hold_overflow_set", int'(overflow[1]), 1);
      clear_overflow = 4'b0010;
      cyc();
      clear_overflow = '0;
      chk("hold_overflow_clr", int'(overflow[1]), 0);
      out_ready = 1'b1;
      cyc();

      // Fairness: requester 0 floods, requester 2 pulses once.
      do_reset();
      latched = 0; served = 0; grants_since = 0; prev_v = 0;
      for (int c = 0; c < 60 && !served; c++) begin
         req_pulse = (c == 3) ? 4'b0101 : 4'b0001;
         cyc();
         if (pending[2] && !latched) latched = 1;
         if (out_valid && !prev_v && latched) begin
            grants_since++;
            if (out_id == 2) begin
               served = 1;
               chk("fair_grant_rank", int'(grants_since <= 2), 1);
            end
         end
         prev_v = out_valid;
      end
      req_pulse = '0;
      chk("fair_served", int'(served), 1);

      // Reset while an event is presented and others are pending.
      do_reset();
      req_pulse = 4'b1010; out_ready = 1'b0;
      wait_valid(10, ok);
      chk("mid_granted", int'(ok), 1);
      chk("mid_pending", int'(pending), 4'b1010);
      reset_n = 1'b0;
      cyc();
      reset_n = 1'b1;
      chk("mid_rst_valid", int'(out_valid), 0);
      chk("mid_rst_id", int'(out_id), 0);
      chk("mid_rst_pending", int'(pending), 0);
      chk("mid_rst_overflow", int'(overflow), 0);
      req_pulse = 4'b1010;
      wait_valid(10, ok);
      chk("mid_regrant", int'(ok), 1);
      chk("mid_regrant_id", int'(out_id), 1);
      out_ready = 1'b1;
      cyc();

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            req_pulse[i]      = ($urandom_range(5) == 0);
            clear_overflow[i] = ($urandom_range(19) == 0);
         end
         out_ready = ($urandom_range(9) < 7);
         reset_n   = ($urandom_range(399) != 0);
         cyc();
         chk("rnd_valid", int'(out_valid), int'(m_valid));
         chk("rnd_id", int'(out_id), m_id);
         chk("rnd_pending", int'(pending), int'(m_pend));
         chk("rnd_overflow", int'(overflow), int'(m_ovf));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
